// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC engine family.
//   state_t      : engine control states (IDLE, SHIFT, DONE)
//   MODE_GEN/CHK : values of the mode input (generate / check)
//   CRC5_USB, CRC8, CRC16_CCITT : common generator polynomials, written
//                  without the implicit x^CRC_W term
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;

  localparam logic [4:0]  CRC5_USB    = 5'b00101;
  localparam logic [7:0]  CRC8        = 8'h07;
  localparam logic [15:0] CRC16_CCITT = 16'h1021;

endpackage

// File: rtl/crc_bit_step.sv
// Single-bit Galois LFSR update, MSB-first.
//   lfsr_in  : current CRC register
//   bit_in   : next message bit
//   lfsr_out : register after absorbing bit_in
// Purely combinational so that a future parallel engine can chain copies.
module crc_bit_step
  import crc_pkg::*;
#(
  parameter int             CRC_W = 5,
  parameter logic [CRC_W-1:0] POLY = CRC5_USB
) (
  input  logic [CRC_W-1:0] lfsr_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] lfsr_out
);

  logic fb;

  assign fb       = lfsr_in[CRC_W-1] ^ bit_in;
  assign lfsr_out = {lfsr_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/serial_crc_engine.sv
// Handshaked serial CRC engine: captures a MSG_W-bit word on start and
// shifts it MSB-first through a Galois LFSR, one bit per clock.
//   clk      : rising-edge clock
//   reset    : asynchronous reset, active-low
//   start    : frame request, accepted while ready=1
//   mode     : 0 generate, 1 check (captured with start)
//   data_in  : message word (captured with start)
//   chk_in   : expected CRC for check mode (captured with start)
//   abort    : cancels a frame in SHIFT; no effect otherwise
//   ready    : engine in IDLE or DONE
//   busy     : engine in SHIFT
//   done     : one-cycle completion pulse
//   data_out : final CRC, held until the next completion
//   crc_err  : check-mode mismatch, held until the next start
module serial_crc_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 5,
  parameter int               MSG_W  = 6,
  parameter logic [CRC_W-1:0] POLY   = CRC5_USB,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter logic [CRC_W-1:0] XOROUT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [MSG_W-1:0] data_in,
  input  logic [CRC_W-1:0] chk_in,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CRC_W-1:0] data_out,
  output logic             crc_err
);

  localparam int CNT_W = $clog2(MSG_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_W - 1);

  state_t state, state_nxt;

  logic [CRC_W-1:0] lfsr;
  logic [CRC_W-1:0] lfsr_nxt;
  logic [CRC_W-1:0] crc_val;
  logic [MSG_W-1:0] shift_reg;
  logic [CNT_W-1:0] count;
  logic [CRC_W-1:0] chk_r;
  logic             mode_r;

  logic load;
  logic step;
  logic finish;
  logic last_bit;

  crc_bit_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .lfsr_in  (lfsr),
    .bit_in   (shift_reg[MSG_W-1]),
    .lfsr_out (lfsr_nxt)
  );

  assign crc_val  = lfsr_nxt ^ XOROUT;
  assign last_bit = (count == LAST_CNT);

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort only matters while shifting; in IDLE/DONE a start always wins.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (last_bit) begin
            state_nxt = DONE;
            finish    = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on load, shift one bit per step, publish on finish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr      <= '0;
      shift_reg <= '0;
      count     <= '0;
      chk_r     <= '0;
      mode_r    <= MODE_GEN;
      data_out  <= '0;
      crc_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        shift_reg <= data_in;
        mode_r    <= mode;
        chk_r     <= chk_in;
        lfsr      <= INIT;
        count     <= '0;
        crc_err   <= 1'b0;
      end else if (step) begin
        lfsr      <= lfsr_nxt;
        shift_reg <= shift_reg << 1;
        count     <= count + 1'b1;
        if (finish) begin
          data_out <= crc_val;
          crc_err  <= (mode_r == MODE_CHK) && (crc_val != chk_r);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_crc_engine.sv
module tb_serial_crc_engine;

  localparam int             CRC_W  = 5;
  localparam int             MSG_W  = 6;
  localparam logic [CRC_W-1:0] POLY   = 5'b00101;
  localparam logic [CRC_W-1:0] INIT   = '0;
  localparam logic [CRC_W-1:0] XOROUT = '0;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             mode;
  logic [MSG_W-1:0] data_in;
  logic [CRC_W-1:0] chk_in;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [CRC_W-1:0] data_out;
  logic             crc_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_crc_engine #(
    .CRC_W  (CRC_W),
    .MSG_W  (MSG_W),
    .POLY   (POLY),
    .INIT   (INIT),
    .XOROUT (XOROUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .data_in  (data_in),
    .chk_in   (chk_in),
    .abort    (abort),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .crc_err  (crc_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference CRC by polynomial long division:
  // remainder of (INIT*x^MSG_W + M(x)*x^CRC_W) mod G(x).
  function automatic logic [CRC_W-1:0] ref_crc(input logic [MSG_W-1:0] d);
    logic [63:0] v;
    logic [63:0] g;
    v = (64'(INIT) << MSG_W) ^ (64'(d) << CRC_W);
    g = (64'd1 << CRC_W) | 64'(POLY);
    for (int i = MSG_W + CRC_W - 1; i >= CRC_W; i--)
      if (v[i]) v = v ^ (g << (i - CRC_W));
    return v[CRC_W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: a frame is a countdown of MSG_W edges whose
  // result is known the moment start is accepted.
  bit             m_busy;
  int             m_left;
  bit             m_done;
  logic [CRC_W-1:0] m_pend;
  logic [CRC_W-1:0] m_data_out;
  bit             m_err_pend;
  bit             m_crc_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_left = 0; m_done = 0;
      m_pend = '0; m_data_out = '0; m_err_pend = 0; m_crc_err = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (abort) begin
          m_busy = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy     = 0;
            m_done     = 1;
            m_data_out = m_pend;
            m_crc_err  = m_err_pend;
          end
        end
      end else if (start) begin
        m_busy     = 1;
        m_left     = MSG_W;
        m_pend     = ref_crc(data_in) ^ XOROUT;
        m_err_pend = mode && (m_pend != chk_in);
        m_crc_err  = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("ready",    32'(ready),    32'(!m_busy));
    check("busy",     32'(busy),     32'(m_busy));
    check("done",     32'(done),     32'(m_done));
    check("data_out", 32'(data_out), 32'(m_data_out));
    check("crc_err",  32'(crc_err),  32'(m_crc_err));
  end

  task automatic issue(input logic [MSG_W-1:0] d, input logic m, input logic [CRC_W-1:0] c);
    start = 1'b1; data_in = d; mode = m; chk_in = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int at_cyc);
    bit seen;
    seen = 0;
    at_cyc = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        at_cyc = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no done pulse within 20 cycles", name);
    end
  endtask

  int t1, t2;

  initial begin
    reset = 1'b0; start = 1'b1; mode = 1'b0; data_in = '0; chk_in = '0; abort = 1'b0;

    // Model pinned against hand-computed values.
    check("ref_101011", 32'(ref_crc(6'b101011)), 32'h13);
    check("ref_111111", 32'(ref_crc(6'b111111)), 32'h1d);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_dout",  32'(data_out), 32'd0);
    check("rst_err",   32'(crc_err),  32'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Generate 101011; done visible after edge MSG_W counted from the start edge.
    t1 = cyc;
    issue(6'b101011, 1'b0, '0);
    wait_done("gen_done", t2);
    check("gen_latency", 32'(t2 - t1), 32'(MSG_W + 1));
    check("gen_dout", 32'(data_out), 32'h13);
    check("gen_err",  32'(crc_err),  32'd0);

    // All-ones, then back-to-back start during the DONE cycle.
    @(posedge clk); #1;
    issue(6'b111111, 1'b0, '0);
    wait_done("ones_done", t1);
    check("ones_dout", 32'(data_out), 32'h1d);
    start = 1'b1; data_in = 6'b101011; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_done", t2);
    check("b2b_spacing", 32'(t2 - t1), 32'd7);
    check("b2b_dout", 32'(data_out), 32'h13);

    // Check mode: match, then mismatch held until next start.
    @(posedge clk); #1;
    issue(6'b101011, 1'b1, 5'b10011);
    wait_done("chk_ok_done", t1);
    check("chk_ok_err", 32'(crc_err), 32'd0);
    @(posedge clk); #1;
    issue(6'b101011, 1'b1, 5'b10010);
    wait_done("chk_bad_done", t1);
    check("chk_bad_err", 32'(crc_err), 32'd1);
    repeat (3) @(negedge clk);
    check("chk_bad_hold", 32'(crc_err), 32'd1);

    // Abort with an ignored start in between; data_out keeps 11101.
    @(posedge clk); #1;
    issue(6'b111111, 1'b0, '0);
    wait_done("pre_abort_done", t1);
    @(posedge clk); #1;
    issue(6'b101011, 1'b0, '0);
    @(posedge clk); #1;
    start = 1'b1; data_in = 6'b000000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_dout",  32'(data_out), 32'h1d);
    repeat (MSG_W) @(posedge clk);
    #1;
    check("abort_dout_late", 32'(data_out), 32'h1d);

    // Asynchronous reset between edges mid-frame.
    issue(6'b101011, 1'b1, 5'b00000);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("areset_busy",  32'(busy),  32'd0);
    check("areset_ready", 32'(ready), 32'd1);
    check("areset_done",  32'(done),  32'd0);
    check("areset_dout",  32'(data_out), 32'd0);
    check("areset_err",   32'(crc_err),  32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(6'b101011, 1'b0, '0);
    wait_done("post_reset_done", t1);
    check("post_reset_dout", 32'(data_out), 32'h13);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 2) == 0);
      data_in = MSG_W'($urandom);
      mode    = 1'($urandom);
      chk_in  = ($urandom_range(0, 1) == 1) ? (ref_crc(data_in) ^ XOROUT) : CRC_W'($urandom);
      abort   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
      end
    end
    start = 1'b0; abort = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
